uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter; the serial source that drives the RX line of the team's UART receive path.
- Accepts bytes from a parallel producer through a single-cycle write strobe into a small FIFO.
- Serialises each byte LSB-first as start(0), 8 data bits, stop(1), at a fixed bit period in clock cycles.
- The bit period matches the receive path (5000 cycles at 100 MHz).

Parameters:
- BIT_PERIOD, 5000, clock cycles per serial bit; legal range 2..8191.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, 2..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- res  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- data_in  input  8  byte to transmit; sampled when en_data_in=1.
- en_data_in  input  1  write strobe; one byte per high cycle.
- full  output  1  registered; 1 when the FIFO holds FIFO_DEPTH bytes.
- overflow  output  1  sticky; set when a write is attempted while full=1.
- busy  output  1  1 when a frame is in flight or the FIFO is non-empty.
- TX  output  1  serial line, registered, idle high.

Behaviour:
- Reset (res=0 at a clock edge):
  - TX=1, full=0, overflow=0, busy=0.
  - FIFO flushed (count=0, pointers 0); bit counter=0; bit index=0; state=IDLE.
  - Reset mid-frame abandons the frame; TX is 1 after that edge.
- Write:
  - Accepted iff en_data_in=1 and full=0 (registered value) in the same cycle.
  - An accepted write stores data_in at the write pointer; pointer wraps modulo FIFO_DEPTH.
  - There is no same-cycle bypass.
  - A write while full=1 is dropped, FIFO is unchanged, and overflow is set to 1 until reset.
- Simultaneous push and pop:
  - Count is unchanged.
  - full follows the new count on the next edge.
  - A write while full=1 is dropped even if a pop occurs in the same cycle.
- States:
  - IDLE: TX=1. If count>0: pop the head into a 8-bit shift register, TX<=0, counter<=0, go to START.
  - START: hold TX=0 for BIT_PERIOD cycles. At counter==BIT_PERIOD-1: counter<=0, TX<=shift[0], index<=0, go to DATA.
  - DATA: hold each bit BIT_PERIOD cycles. At terminal count: shift right and increment index. After index 7 completes, TX<=1 and go to STOP.
  - STOP: hold TX=1 for BIT_PERIOD cycles. At terminal count:
    - if count>0, pop, TX<=0, go directly to START (no extra idle cycle);
    - else go to IDLE.
- Latency: a write accepted at edge E0 into an empty FIFO with state IDLE → pop at E1 → TX low after E2.
- Frame length: exactly 10*BIT_PERIOD cycles with the feature off. Back-to-back frames are contiguous.
- busy: combinational OR of (state!=IDLE) and (count!=0).
- Counter width is 13 bits; count width is log2(FIFO_DEPTH)+1.
- Unused state encodings return to IDLE with TX=1.

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- Defined: STOP holds TX=1 for 2*BIT_PERIOD cycles; frame is 11*BIT_PERIOD cycles. Gives the receiver extra idle margin between frames.
- Undefined: a single stop bit of BIT_PERIOD cycles; frame is 10*BIT_PERIOD cycles.
- No port or parameter changes either way.

Test Plan:
- Reset then idle 100 cycles → TX=1, busy=0, full=0, overflow=0 throughout.
- BIT_PERIOD=16; write 8'hA5 → TX low 2 cycles after the write edge; line sequence 0,1,0,1,0,0,1,0,1,1, each level 16 cycles; busy falls after 160 cycles.
- Write 8'h26 then 8'hAA on consecutive cycles → two contiguous frames, 320 cycles total with no idle gap; decoded bytes 8'h26, 8'hAA in order.
- FIFO_DEPTH=4, six writes in consecutive cycles starting from idle → first byte popped at E1 so the FIFO holds four bytes; full=1 after the 5th accepted write, 6th write dropped, overflow=1. Exactly five frames are transmitted.
- Assert res=0 at cycle 50 of a frame with BIT_PERIOD=16 → TX=1 after that edge; FIFO empty, busy=0, no further frame after release.
- With UART_TX_STOP2_EN defined, write 8'h00 twice → each stop-high segment is 32 cycles; second start bit begins 176 cycles after the first.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_STOP2_EN for two stop bits
module uart_tx_fifo #(
  parameter int BIT_PERIOD = 5000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] data_in,
  input  logic       en_data_in,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [12:0] LAST = 13'(BIT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q, count_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic full_q, ovf_q, line_q, line_d, tx_q;
  logic push, pop, term, stop_last;
  assign push = en_data_in && !full_q;
  assign term = cnt_q == LAST;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef UART_TX_STOP2_EN
  assign stop_last = idx_q[0];
`else
  assign stop_last = 1'b1;
`endif
  assign full = full_q;
  assign overflow = ovf_q;
  assign busy = (state_q != IDLE) || (|count_q);
  assign TX = tx_q;
  // frame sequencer: line level, bit timing, shift register and FIFO pop
  always_comb begin
    state_d = state_q;
    line_d = line_q;
    cnt_d = term ? 13'd0 : cnt_q + 13'd1;
    idx_d = idx_q;
    sh_d = sh_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 13'd0;
        line_d = 1'b1;
        if (|count_q) begin
          pop = 1'b1;
          sh_d = mem_q[rd_q];
          line_d = 1'b0;
          state_d = START;
        end
      end
      START: if (term) begin
        line_d = sh_q[0];
        idx_d = 3'd0;
        state_d = DATA;
      end
      DATA: if (term) begin
        sh_d = {1'b0, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        line_d = (idx_q == 3'd7) ? 1'b1 : sh_q[1];
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (term) begin
        if (!stop_last) idx_d = 3'd1;
        else if (|count_q) begin
          pop = 1'b1;
          sh_d = mem_q[rd_q];
          line_d = 1'b0;
          state_d = START;
        end else state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        line_d = 1'b1;
        cnt_d = 13'd0;
      end
    endcase
  end
  // state, FIFO bookkeeping and a retiming flop on the serial line
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      cnt_q <= 13'd0;
      idx_q <= 3'd0;
      sh_q <= 8'd0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      line_q <= 1'b1;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      count_q <= count_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      full_q <= count_d == (AW+1)'(FIFO_DEPTH);
      ovf_q <= ovf_q | (en_data_in & full_q);
      line_q <= line_d;
      tx_q <= line_q;
    end
  end
  // FIFO storage; contents need no reset since the pointers are cleared
  always_ff @(posedge clk) begin
    if (res && push) mem_q[wr_q] <= data_in;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; stimulus queues expected bytes, a line decoder checks frames
module tb_uart_tx_fifo;
  localparam int BP = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_STOP2_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int FRAME = (9 + STOPS) * BP;
  logic clk = 1'b0, res = 1'b0, en_data_in = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic full, overflow, busy, TX;
  int total = 0, bad = 0, cyc = 0, rst_edges = 0, nframes = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_fifo #(.BIT_PERIOD(BP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .res(res), .data_in(data_in), .en_data_in(en_data_in),
    .full(full), .overflow(overflow), .busy(busy), .TX(TX)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!res) rst_edges <= rst_edges + 1;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", n, act, req, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_idle(input string n);
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({n, "_idle"}, 32'(busy), 0);
    repeat (BP) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b, input bit sent);
    en_data_in = 1'b1;
    data_in = b;
    if (sent) exp_q.push_back(b);
    @(negedge clk);
    en_data_in = 1'b0;
  endtask

  initial begin : monitor
    logic [7:0] b;
    int r, s;
    forever begin
      @(negedge clk);
      if (res && TX === 1'b0) begin
        s = cyc;
        r = rst_edges;
        repeat (BP / 2) @(negedge clk);
        if (r == rst_edges) chk("start_bit", 32'(TX), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = TX;
        end
        for (int i = 0; i < STOPS; i++) begin
          repeat (BP) @(negedge clk);
          if (r == rst_edges) chk("stop_bit", 32'(TX), 1);
        end
        if (r == rst_edges) begin
          nframes++;
          starts.push_back(s);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_frame: got %0h want none", b);
          end else chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : stimulus
    int c0, n0;
    logic [9:0] seq;
    @(negedge clk);
    chk("rst_tx", 32'(TX), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(TX), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_full", 32'(full), 0);
      chk("idle_ovf", 32'(overflow), 0);
    end
    n0 = nframes;
    seq = {1'b1, 8'hA5, 1'b0};
    wr(8'hA5, 1'b1);
    c0 = cyc;
    chk("a5_busy_rise", 32'(busy), 1);
    wait_to(c0 + 1);
    chk("a5_latency_e1", 32'(TX), 1);
    for (int k = 0; k < 10; k++) begin
      wait_to(c0 + 2 + BP * k);
      chk("a5_level_first", 32'(TX), 32'(seq[k]));
      if (k < 9) begin
        wait_to(c0 + 1 + BP * (k + 1));
        chk("a5_level_last", 32'(TX), 32'(seq[k]));
      end
    end
    wait_to(c0 + FRAME);
    chk("a5_busy_hold", 32'(busy), 1);
    chk("a5_stop_high", 32'(TX), 1);
    wait_to(c0 + FRAME + 1);
    chk("a5_busy_fall", 32'(busy), 0);
    wait_idle("a5");
    chk("a5_frames", nframes - n0, 1);
    starts.delete();
    n0 = nframes;
    wr(8'h26, 1'b1);
    wr(8'hAA, 1'b1);
    wait_idle("pair");
    chk("pair_frames", nframes - n0, 2);
    if (starts.size() == 2) chk("pair_gap", starts[1] - starts[0], FRAME);
    n0 = nframes;
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    wr(8'h44, 1'b1);
    chk("full_before5", 32'(full), 0);
    wr(8'h55, 1'b1);
    chk("full_after5", 32'(full), 1);
    chk("ovf_before6", 32'(overflow), 0);
    wr(8'h66, 1'b0);
    chk("full_after6", 32'(full), 1);
    chk("ovf_after6", 32'(overflow), 1);
    wait_idle("burst");
    chk("burst_frames", nframes - n0, 5);
    chk("burst_ovf_sticky", 32'(overflow), 1);
    chk("burst_full_clear", 32'(full), 0);
    chk("burst_queue", exp_q.size(), 0);
    res = 1'b0;
    @(negedge clk);
    chk("rst_ovf_clear", 32'(overflow), 0);
    res = 1'b1;
    repeat (4) @(negedge clk);
    n0 = nframes;
    wr(8'h5A, 1'b0);
    c0 = cyc;
    wait_to(c0 + 51);
    chk("midrst_tx_low", 32'(TX), 0);
    res = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(TX), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_full", 32'(full), 0);
    res = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("postrst_tx", 32'(TX), 1);
      chk("postrst_busy", 32'(busy), 0);
    end
    chk("postrst_frames", nframes - n0, 0);
    starts.delete();
    n0 = nframes;
    wr(8'h00, 1'b1);
    c0 = cyc;
    wr(8'h00, 1'b1);
    wait_to(c0 + 1 + 9 * BP);
    chk("zero_bit7", 32'(TX), 0);
    wait_to(c0 + 2 + 9 * BP);
    chk("zero_stop_first", 32'(TX), 1);
    wait_to(c0 + 1 + FRAME);
    chk("zero_stop_last", 32'(TX), 1);
    wait_to(c0 + 2 + FRAME);
    chk("zero_next_start", 32'(TX), 0);
    wait_idle("zero");
    chk("zero_frames", nframes - n0, 2);
    if (starts.size() == 2) chk("zero_gap", starts[1] - starts[0], FRAME);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
